// File: rtl/tlbelo_csr.sv
// EntryLo CSR bank: per-channel TLB EntryLo registers written by CSR
// instructions and bulk-loaded by a TLBRD handshake with the TLB array.
module tlbelo_csr #(
  parameter  int PALEN   = 32,
  parameter  int NUM_ELO = 2,
  localparam int PPN_W   = PALEN - 12,
  localparam int SEL_W   = (NUM_ELO > 1) ? $clog2(NUM_ELO) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csr_wr_en,
  input  logic [SEL_W-1:0]         csr_wr_sel,
  input  logic [31:0]              csr_wr_data,
  input  logic [31:0]              csr_wr_mask,
  input  logic [SEL_W-1:0]         csr_rd_sel,
  output logic [31:0]              csr_rd_data,
  input  logic                     tlbrd_req,
  input  logic                     tlbrd_abort,
  output logic                     tlbrd_busy,
  input  logic                     tlb_rsp_valid,
  input  logic                     tlb_rsp_e,
  input  logic [NUM_ELO*PPN_W-1:0] tlb_rsp_ppn,
  input  logic [NUM_ELO*6-1:0]     tlb_rsp_flags,
  input  logic                     tlb_rsp_g,
  output logic                     tlbrd_done,
  output logic [NUM_ELO*32-1:0]    elo_out
);

  // Writable bits: [6:0] flags/G and [PALEN-5:8] PPN; bit 7 and upper bits stay zero.
  localparam logic [63:0] PA_SPAN = (64'd1 << (PALEN - 4)) - 64'd1;
  localparam logic [31:0] WMASK   = PA_SPAN[31:0] & ~32'h0000_0080;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic        accept;
  logic [31:0] elo_q [NUM_ELO];
  logic [31:0] elo_d [NUM_ELO];
  logic [31:0] rsp_word;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (tlbrd_req) state_d = WAIT;
      WAIT: begin
        if (tlbrd_abort) begin
          state_d = IDLE;
        end else if (tlb_rsp_valid) begin
          state_d = IDLE;
          accept  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = accept;
  end

  // An accepted response overrides a coincident CSR write on every channel.
  always_comb begin
    rsp_word = '0;
    for (int unsigned i = 0; i < NUM_ELO; i++) begin
      elo_d[i] = elo_q[i];
      if (csr_wr_en && (csr_wr_sel == SEL_W'(i))) begin
        elo_d[i] = ((elo_q[i] & ~csr_wr_mask) | (csr_wr_data & csr_wr_mask)) & WMASK;
      end
      if (accept) begin
        rsp_word          = '0;
        rsp_word[8 +: PPN_W] = tlb_rsp_ppn[i*PPN_W +: PPN_W];
        rsp_word[6]       = tlb_rsp_g;
        rsp_word[5:0]     = tlb_rsp_flags[i*6 +: 6];
        elo_d[i]          = tlb_rsp_e ? (rsp_word & WMASK) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      elo_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      elo_q   <= elo_d;
    end
  end

  always_comb begin
    csr_rd_data = '0;
    elo_out     = '0;
    for (int unsigned i = 0; i < NUM_ELO; i++) begin
      elo_out[i*32 +: 32] = elo_q[i];
      if (csr_rd_sel == SEL_W'(i)) csr_rd_data = elo_q[i];
    end
  end

  assign tlbrd_busy = (state_q == WAIT);
  assign tlbrd_done = done_q;

endmodule

// File: tb/tb_tlbelo_csr.sv
// Directed bench for tlbelo_csr: default build plus PALEN=36/NUM_ELO=4 and NUM_ELO=3 builds.
module tb_tlbelo_csr;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_pass  = 0;
  int n_total = 0;

  // Instance A: PALEN=32, NUM_ELO=2
  logic        a_wr_en, a_req, a_abort, a_busy, a_rsp_valid, a_rsp_e, a_g, a_done;
  logic [0:0]  a_wr_sel, a_rd_sel;
  logic [31:0] a_wr_data, a_wr_mask, a_rd_data;
  logic [39:0] a_ppn;
  logic [11:0] a_flags;
  logic [63:0] a_elo;

  // Instance B: PALEN=36, NUM_ELO=4
  logic         b_wr_en, b_req, b_abort, b_busy, b_rsp_valid, b_rsp_e, b_g, b_done;
  logic [1:0]   b_wr_sel, b_rd_sel;
  logic [31:0]  b_wr_data, b_wr_mask, b_rd_data;
  logic [95:0]  b_ppn;
  logic [23:0]  b_flags;
  logic [127:0] b_elo;

  // Instance C: PALEN=32, NUM_ELO=3 (select value 3 is out of range)
  logic        c_wr_en, c_req, c_abort, c_busy, c_rsp_valid, c_rsp_e, c_g, c_done;
  logic [1:0]  c_wr_sel, c_rd_sel;
  logic [31:0] c_wr_data, c_wr_mask, c_rd_data;
  logic [59:0] c_ppn;
  logic [17:0] c_flags;
  logic [95:0] c_elo;

  tlbelo_csr #(.PALEN(32), .NUM_ELO(2)) dut_a (
    .clk(clk), .rst(rst), .csr_wr_en(a_wr_en), .csr_wr_sel(a_wr_sel),
    .csr_wr_data(a_wr_data), .csr_wr_mask(a_wr_mask), .csr_rd_sel(a_rd_sel),
    .csr_rd_data(a_rd_data), .tlbrd_req(a_req), .tlbrd_abort(a_abort),
    .tlbrd_busy(a_busy), .tlb_rsp_valid(a_rsp_valid), .tlb_rsp_e(a_rsp_e),
    .tlb_rsp_ppn(a_ppn), .tlb_rsp_flags(a_flags), .tlb_rsp_g(a_g),
    .tlbrd_done(a_done), .elo_out(a_elo)
  );

  tlbelo_csr #(.PALEN(36), .NUM_ELO(4)) dut_b (
    .clk(clk), .rst(rst), .csr_wr_en(b_wr_en), .csr_wr_sel(b_wr_sel),
    .csr_wr_data(b_wr_data), .csr_wr_mask(b_wr_mask), .csr_rd_sel(b_rd_sel),
    .csr_rd_data(b_rd_data), .tlbrd_req(b_req), .tlbrd_abort(b_abort),
    .tlbrd_busy(b_busy), .tlb_rsp_valid(b_rsp_valid), .tlb_rsp_e(b_rsp_e),
    .tlb_rsp_ppn(b_ppn), .tlb_rsp_flags(b_flags), .tlb_rsp_g(b_g),
    .tlbrd_done(b_done), .elo_out(b_elo)
  );

  tlbelo_csr #(.PALEN(32), .NUM_ELO(3)) dut_c (
    .clk(clk), .rst(rst), .csr_wr_en(c_wr_en), .csr_wr_sel(c_wr_sel),
    .csr_wr_data(c_wr_data), .csr_wr_mask(c_wr_mask), .csr_rd_sel(c_rd_sel),
    .csr_rd_data(c_rd_data), .tlbrd_req(c_req), .tlbrd_abort(c_abort),
    .tlbrd_busy(c_busy), .tlb_rsp_valid(c_rsp_valid), .tlb_rsp_e(c_rsp_e),
    .tlb_rsp_ppn(c_ppn), .tlb_rsp_flags(c_flags), .tlb_rsp_g(c_g),
    .tlbrd_done(c_done), .elo_out(c_elo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    n_total++; if (a_busy !== 1'b0) $display("FAIL reset_a_busy: got %b want 0", a_busy); else n_pass++;
    n_total++; if (a_done !== 1'b0) $display("FAIL reset_a_done: got %b want 0", a_done); else n_pass++;
    n_total++; if (a_elo !== 64'h0) $display("FAIL reset_a_elo: got %h want 0", a_elo); else n_pass++;
    n_total++; if (b_elo !== 128'h0) $display("FAIL reset_b_elo: got %h want 0", b_elo); else n_pass++;
    n_total++; if (c_elo !== 96'h0) $display("FAIL reset_c_elo: got %h want 0", c_elo); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_masked_write;
    a_wr_en = 1'b1; a_wr_sel = 1'b0; a_wr_data = 32'h0FFF_FF7F; a_wr_mask = 32'hFFFF_FFFF;
    tick();
    a_rd_sel = 1'b0; #1;
    n_total++; if (a_rd_data !== 32'h0FFF_FF7F) $display("FAIL csrwr_ch0: got %h want 0fffff7f", a_rd_data); else n_pass++;
    a_wr_data = 32'h0; a_wr_mask = 32'h0000_0001;
    tick();
    n_total++; if (a_rd_data !== 32'h0FFF_FF7E) $display("FAIL csrxchg_ch0: got %h want 0fffff7e", a_rd_data); else n_pass++;
    a_wr_sel = 1'b1; a_wr_data = 32'hFFFF_FFFF; a_wr_mask = 32'hFFFF_FFFF;
    tick();
    a_rd_sel = 1'b1; #1;
    n_total++; if (a_rd_data !== 32'h0FFF_FF7F) $display("FAIL reserved_ch1: got %h want 0fffff7f", a_rd_data); else n_pass++;
    a_wr_data = 32'h0; a_wr_mask = 32'h0000_FF00;
    tick();
    a_wr_en = 1'b0;
    n_total++; if (a_elo !== {32'h0FFF_007F, 32'h0FFF_FF7E}) $display("FAIL partial_mask_elo: got %h want 0fff007f0fffff7e", a_elo); else n_pass++;
  endtask

  task automatic test_tlbrd_hit;
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    n_total++; if (a_busy !== 1'b1) $display("FAIL hit_busy_c1: got %b want 1", a_busy); else n_pass++;
    n_total++; if (a_done !== 1'b0) $display("FAIL hit_done_c1: got %b want 0", a_done); else n_pass++;
    tick();
    n_total++; if (a_busy !== 1'b1) $display("FAIL hit_busy_c2: got %b want 1", a_busy); else n_pass++;
    a_req = 1'b1;
    tick();
    n_total++; if (a_busy !== 1'b1) $display("FAIL hit_busy_c3: got %b want 1", a_busy); else n_pass++;
    n_total++; if (a_elo !== {32'h0FFF_007F, 32'h0FFF_FF7E}) $display("FAIL hit_elo_pending: got %h want 0fff007f0fffff7e", a_elo); else n_pass++;
    a_rsp_valid = 1'b1; a_rsp_e = 1'b1; a_g = 1'b1;
    a_ppn = {20'h12345, 20'hABCDE}; a_flags = {6'b101010, 6'b010111};
    tick();
    a_rsp_valid = 1'b0; a_req = 1'b0;
    n_total++; if (a_busy !== 1'b0) $display("FAIL hit_busy_end: got %b want 0", a_busy); else n_pass++;
    n_total++; if (a_done !== 1'b1) $display("FAIL hit_done: got %b want 1", a_done); else n_pass++;
    a_rd_sel = 1'b0; #1;
    n_total++; if (a_rd_data !== 32'h0ABC_DE57) $display("FAIL hit_ch0: got %h want 0abcde57", a_rd_data); else n_pass++;
    a_rd_sel = 1'b1; #1;
    n_total++; if (a_rd_data !== 32'h0123_456A) $display("FAIL hit_ch1: got %h want 0123456a", a_rd_data); else n_pass++;
    tick();
    n_total++; if (a_done !== 1'b0) $display("FAIL hit_done_pulse: got %b want 0", a_done); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL hit_no_requeue: got %b want 0", a_busy); else n_pass++;
  endtask

  task automatic test_tlbrd_miss;
    a_wr_en = 1'b1; a_wr_mask = 32'hFFFF_FFFF;
    a_wr_sel = 1'b0; a_wr_data = 32'h0000_0011;
    tick();
    a_wr_sel = 1'b1; a_wr_data = 32'h0000_2200;
    tick();
    a_wr_en = 1'b0;
    n_total++; if (a_elo !== {32'h0000_2200, 32'h0000_0011}) $display("FAIL miss_preload: got %h want 0000220000000011", a_elo); else n_pass++;
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    a_rsp_valid = 1'b1; a_rsp_e = 1'b0;
    tick();
    a_rsp_valid = 1'b0;
    n_total++; if (a_done !== 1'b1) $display("FAIL miss_done: got %b want 1", a_done); else n_pass++;
    n_total++; if (a_elo !== 64'h0) $display("FAIL miss_elo: got %h want 0", a_elo); else n_pass++;
    tick();
    n_total++; if (a_done !== 1'b0) $display("FAIL miss_done_pulse: got %b want 0", a_done); else n_pass++;
  endtask

  task automatic test_collisions;
    a_wr_en = 1'b1; a_wr_mask = 32'hFFFF_FFFF;
    a_wr_sel = 1'b0; a_wr_data = 32'h0000_0123;
    tick();
    a_wr_sel = 1'b1; a_wr_data = 32'h0000_0456;
    tick();
    a_wr_en = 1'b0;
    // abort coincident with a valid response
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    a_rsp_valid = 1'b1; a_rsp_e = 1'b1; a_abort = 1'b1;
    tick();
    a_rsp_valid = 1'b0; a_abort = 1'b0;
    n_total++; if (a_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", a_busy); else n_pass++;
    n_total++; if (a_done !== 1'b0) $display("FAIL abort_done: got %b want 0", a_done); else n_pass++;
    n_total++; if (a_elo !== {32'h0000_0456, 32'h0000_0123}) $display("FAIL abort_elo: got %h want 0000045600000123", a_elo); else n_pass++;
    // stray response in IDLE
    a_rsp_valid = 1'b1; a_rsp_e = 1'b0;
    tick();
    a_rsp_valid = 1'b0;
    n_total++; if (a_done !== 1'b0) $display("FAIL stray_done: got %b want 0", a_done); else n_pass++;
    n_total++; if (a_elo !== {32'h0000_0456, 32'h0000_0123}) $display("FAIL stray_elo: got %h want 0000045600000123", a_elo); else n_pass++;
    // CSR write to ch1 coincident with an accepted response
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    a_wr_en = 1'b1; a_wr_sel = 1'b1; a_wr_data = 32'hFFFF_FFFF; a_wr_mask = 32'hFFFF_FFFF;
    a_rsp_valid = 1'b1; a_rsp_e = 1'b1; a_g = 1'b0;
    a_ppn = {20'h00F0F, 20'h00001}; a_flags = {6'b000011, 6'b000000};
    tick();
    a_wr_en = 1'b0; a_rsp_valid = 1'b0;
    n_total++; if (a_done !== 1'b1) $display("FAIL wr_rsp_done: got %b want 1", a_done); else n_pass++;
    n_total++; if (a_elo !== {32'h000F_0F03, 32'h0000_0100}) $display("FAIL wr_rsp_elo: got %h want 000f0f0300000100", a_elo); else n_pass++;
    // response in the same cycle as the request is too early
    a_req = 1'b1; a_rsp_valid = 1'b1; a_rsp_e = 1'b0;
    tick();
    a_req = 1'b0; a_rsp_valid = 1'b0;
    n_total++; if (a_busy !== 1'b1) $display("FAIL early_rsp_busy: got %b want 1", a_busy); else n_pass++;
    n_total++; if (a_done !== 1'b0) $display("FAIL early_rsp_done: got %b want 0", a_done); else n_pass++;
    n_total++; if (a_elo !== {32'h000F_0F03, 32'h0000_0100}) $display("FAIL early_rsp_elo: got %h want 000f0f0300000100", a_elo); else n_pass++;
    // CSR write while waiting applies, then a response overwrites it
    a_wr_en = 1'b1; a_wr_sel = 1'b0; a_wr_data = 32'h0000_0077;
    tick();
    a_wr_en = 1'b0;
    a_rd_sel = 1'b0; #1;
    n_total++; if (a_rd_data !== 32'h0000_0077) $display("FAIL wait_wr_ch0: got %h want 00000077", a_rd_data); else n_pass++;
    n_total++; if (a_busy !== 1'b1) $display("FAIL wait_wr_busy: got %b want 1", a_busy); else n_pass++;
    a_rsp_valid = 1'b1; a_rsp_e = 1'b1; a_g = 1'b0;
    a_ppn = {20'h00000, 20'h00002}; a_flags = 12'h000;
    tick();
    a_rsp_valid = 1'b0;
    n_total++; if (a_elo !== {32'h0000_0000, 32'h0000_0200}) $display("FAIL wait_wr_overwrite: got %h want 0000000000000200", a_elo); else n_pass++;
  endtask

  task automatic test_param_sweep;
    b_wr_en = 1'b1; b_wr_sel = 2'd3; b_wr_data = 32'hFFFF_FFFF; b_wr_mask = 32'hFFFF_FFFF;
    tick();
    b_wr_en = 1'b0;
    b_rd_sel = 2'd3; #1;
    n_total++; if (b_rd_data !== 32'hFFFF_FF7F) $display("FAIL b_csrwr_ch3: got %h want ffffff7f", b_rd_data); else n_pass++;
    b_req = 1'b1;
    tick();
    b_req = 1'b0;
    n_total++; if (b_busy !== 1'b1) $display("FAIL b_busy: got %b want 1", b_busy); else n_pass++;
    b_rsp_valid = 1'b1; b_rsp_e = 1'b1; b_g = 1'b1; b_ppn = {96{1'b1}};
    b_flags = {6'h3F, 6'h2A, 6'h15, 6'h00};
    tick();
    b_rsp_valid = 1'b0;
    n_total++; if (b_done !== 1'b1) $display("FAIL b_done: got %b want 1", b_done); else n_pass++;
    n_total++; if (b_elo !== {32'hFFFF_FF7F, 32'hFFFF_FF6A, 32'hFFFF_FF55, 32'hFFFF_FF40})
      $display("FAIL b_hit_elo: got %h want ffffff7fffffff6affffff55ffffff40", b_elo); else n_pass++;
    b_rd_sel = 2'd2; #1;
    n_total++; if (b_rd_data !== 32'hFFFF_FF6A) $display("FAIL b_rd_ch2: got %h want ffffff6a", b_rd_data); else n_pass++;
    // NUM_ELO=3: select 3 is out of range for both write and read
    c_wr_en = 1'b1; c_wr_mask = 32'hFFFF_FFFF; c_wr_data = 32'hFFFF_FFFF; c_wr_sel = 2'd2;
    tick();
    c_wr_sel = 2'd3;
    tick();
    c_wr_en = 1'b0;
    n_total++; if (c_elo !== {32'h0FFF_FF7F, 32'h0, 32'h0}) $display("FAIL c_oor_write: got %h want 0fffff7f0000000000000000", c_elo); else n_pass++;
    c_rd_sel = 2'd3; #1;
    n_total++; if (c_rd_data !== 32'h0) $display("FAIL c_oor_read: got %h want 0", c_rd_data); else n_pass++;
    c_rd_sel = 2'd2; #1;
    n_total++; if (c_rd_data !== 32'h0FFF_FF7F) $display("FAIL c_rd_ch2: got %h want 0fffff7f", c_rd_data); else n_pass++;
  endtask

  task automatic test_reset_in_wait;
    b_req = 1'b1;
    tick();
    b_req = 1'b0;
    n_total++; if (b_busy !== 1'b1) $display("FAIL rstwait_busy_pre: got %b want 1", b_busy); else n_pass++;
    rst = 1'b1; b_req = 1'b1;
    b_wr_en = 1'b1; b_wr_sel = 2'd0; b_wr_data = 32'hFFFF_FFFF; b_wr_mask = 32'hFFFF_FFFF;
    b_rsp_valid = 1'b1;
    tick();
    rst = 1'b0; b_req = 1'b0; b_wr_en = 1'b0; b_rsp_valid = 1'b0;
    n_total++; if (b_busy !== 1'b0) $display("FAIL rstwait_busy: got %b want 0", b_busy); else n_pass++;
    n_total++; if (b_done !== 1'b0) $display("FAIL rstwait_done: got %b want 0", b_done); else n_pass++;
    n_total++; if (b_elo !== 128'h0) $display("FAIL rstwait_elo: got %h want 0", b_elo); else n_pass++;
    b_rsp_valid = 1'b1; b_rsp_e = 1'b1;
    tick();
    b_rsp_valid = 1'b0;
    n_total++; if (b_done !== 1'b0) $display("FAIL rstwait_late_done: got %b want 0", b_done); else n_pass++;
    n_total++; if (b_elo !== 128'h0) $display("FAIL rstwait_late_elo: got %h want 0", b_elo); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    {a_wr_en, a_req, a_abort, a_rsp_valid, a_rsp_e, a_g} = '0;
    a_wr_sel = '0; a_rd_sel = '0; a_wr_data = '0; a_wr_mask = '0; a_ppn = '0; a_flags = '0;
    {b_wr_en, b_req, b_abort, b_rsp_valid, b_rsp_e, b_g} = '0;
    b_wr_sel = '0; b_rd_sel = '0; b_wr_data = '0; b_wr_mask = '0; b_ppn = '0; b_flags = '0;
    {c_wr_en, c_req, c_abort, c_rsp_valid, c_rsp_e, c_g} = '0;
    c_wr_sel = '0; c_rd_sel = '0; c_wr_data = '0; c_wr_mask = '0; c_ppn = '0; c_flags = '0;
    @(negedge clk);
    test_reset();
    test_masked_write();
    test_tlbrd_hit();
    test_tlbrd_miss();
    test_collisions();
    test_param_sweep();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
